// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and baud divisor helper.
// Defining UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic int calc_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter; tc is high during the last cycle of a loaded interval,
// so loading N makes the owner act on tc exactly N edges later.
module uart_baud_cnt #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= ZERO;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != ZERO) begin
            cnt <= cnt - ONE;
        end
    end

    assign tc = (cnt == ONE);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; defining UART_RX_PARITY_EN makes it 8E1.
// One-entry holding register with valid/ready handoff plus error pulses.
//
// state     | meaning
// ST_IDLE   | waiting for a falling edge on the synchronized line
// ST_START  | half-bit wait, then confirm the start bit is still low
// ST_DATA   | sampling 8 data bits at bit centre, LSB first
// ST_PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// ST_STOP   | sampling the stop bit, then completing or reporting errors
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CPB   = calc_cpb(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CPB);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CPB / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    uart_state_t          state;
    logic                 sync1, sync2, line_prev;
    logic [1:0]           warm;
    logic                 armed;
    logic                 fall;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_val;
    logic                 tc;
    logic                 par_bad;
    logic                 done;

    // The synchronizer resets high, so a line that is already low at release
    // would look like an edge; arm only after a real high has been observed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            warm      <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync1     <= ser_rx;
            sync2     <= sync1;
            line_prev <= sync2;
            warm      <= {warm[0], 1'b1};
            armed     <= armed | (warm[1] & sync2);
        end
    end

    assign fall = armed & line_prev & ~sync2;

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = FULL_BIT;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    cnt_load = 1'b1;
                    cnt_val  = HALF_BIT;
                end
            end
            ST_START:  cnt_load = tc & ~sync2;
            ST_DATA:   cnt_load = tc;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: cnt_load = tc;
`endif
            default:   cnt_load = 1'b0;
        endcase
    end

    uart_baud_cnt #(.WIDTH(CNT_W)) u_baud_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (tc)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = (^shift) ^ par_bit;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign done = (state == ST_STOP) && tc && sync2 && !par_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= done && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    bit_idx <= '0;
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    if (tc) state <= sync2 ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (tc) begin
                        shift   <= {sync2, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_ONE;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tc) begin
                        par_bit <= sync2;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tc) begin
                        frame_err <= ~sync2;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A completed byte may replace the held one only in a transfer cycle.
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (434 clocks per bit).
// Build with UART_RX_PARITY_EN to exercise the 8E1 variant.
module tb_uart_rx;

    localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 4126 + CPB;
`else
    localparam int LAT = 4126;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ser_rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    always #10 clk = ~clk;

    uart_rx #(.CLK_HZ(50000000), .BAUD(115200)) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_rx     (ser_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid = -1;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (frame_err)  ferr_cnt++;
            if (overrun)    ovr_cnt++;
            if (parity_err) perr_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        valid_cycles = 0;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        perr_cnt     = 0;
        first_valid  = -1;
    endtask

    // bits[0] is the start bit; transmitted LSB first, then idle high for one bit.
    task automatic send_bits(input logic [10:0] bits, input int n);
        @(negedge clk);
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            ser_rx = bits[i];
            wait_cycles(CPB);
        end
        ser_rx = 1'b1;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
        send_bits({stop_b, ^d, d, 1'b0}, 11);
`else
        send_bits({1'b1, stop_b, d, 1'b0}, 10);
`endif
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'hFF, 1'b0, 0, 8'h55, 1};
        vecs[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[4] = '{8'hA5, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0};

        wait_cycles(5);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_ovr", int'(overrun), 0);
        chk("reset_perr", int'(parity_err), 0);
        reset = 1'b1;
        wait_cycles(10);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop_bit);
            wait_cycles(10);
            chk($sformatf("vec%0d_valid_cycles", v), valid_cycles, vecs[v].exp_valid);
            chk($sformatf("vec%0d_data", v), int'(rx_data), int'(vecs[v].exp_data));
            chk($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_ovr", v), ovr_cnt, 0);
            chk($sformatf("vec%0d_perr", v), perr_cnt, 0);
            if (vecs[v].exp_valid != 0)
                chk($sformatf("vec%0d_latency_ok", v),
                    int'((first_valid - start_cyc >= LAT - 3) && (first_valid - start_cyc <= LAT + 3)), 1);
        end

        // Held byte with consumer stalled: second byte overruns.
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_cycles(10);
        chk("ovr_data_held", int'(rx_data), 8'hA3);
        chk("ovr_valid_held", int'(rx_valid), 1);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_ferr", ferr_cnt, 0);
        rx_ready = 1'b1;
        wait_cycles(1);
        chk("ovr_valid_cleared", int'(rx_valid), 0);
        chk("ovr_data_after", int'(rx_data), 8'hA3);

        // Short low glitch must be rejected at the half-bit check.
        clear_mon();
        ser_rx = 1'b0;
        wait_cycles(100);
        ser_rx = 1'b1;
        wait_cycles(800);
        chk("glitch_valid", valid_cycles, 0);
        chk("glitch_ferr", ferr_cnt, 0);
        chk("glitch_ovr", ovr_cnt, 0);
        send_frame(8'h3C, 1'b1);
        wait_cycles(10);
        chk("glitch_next_valid", valid_cycles, 1);
        chk("glitch_next_data", int'(rx_data), 8'h3C);

        // Reset mid-frame with the line held low through release.
        clear_mon();
        ser_rx = 1'b0;
        wait_cycles(1000);
        reset = 1'b0;
        wait_cycles(3);
        chk("rst_mid_valid", int'(rx_valid), 0);
        chk("rst_mid_data", int'(rx_data), 0);
        chk("rst_mid_ferr", int'(frame_err), 0);
        chk("rst_mid_ovr", int'(overrun), 0);
        reset = 1'b1;
        wait_cycles(6000);
        chk("rst_low_no_valid", valid_cycles, 0);
        chk("rst_low_no_ferr", ferr_cnt, 0);
        chk("rst_low_data", int'(rx_data), 0);
        ser_rx = 1'b1;
        wait_cycles(50);
        send_frame(8'h5A, 1'b1);
        wait_cycles(10);
        chk("rst_after_valid", valid_cycles, 1);
        chk("rst_after_data", int'(rx_data), 8'h5A);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit must be 1.
        clear_mon();
        send_bits({1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        wait_cycles(10);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_valid", valid_cycles, 0);
        chk("par_bad_data", int'(rx_data), 8'h5A);
        clear_mon();
        send_bits({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        wait_cycles(10);
        chk("par_ok_perr", perr_cnt, 0);
        chk("par_ok_valid", valid_cycles, 1);
        chk("par_ok_data", int'(rx_data), 8'h07);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
